// File: rtl/ripple_count_sampler_if.sv
// Valid/ready hand-off of accepted counter values to the next stage.
interface ripple_count_sampler_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter bus, rejects transients, flags match/wrap
// events and hands each newly accepted value to a one-entry valid/ready buffer.
module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      q_in,
  input  logic                  cmp_en,
  input  logic [WIDTH-1:0]      cmp_value,
  ripple_count_sampler_if.master out_bus,
  output logic                  match_pulse,
  output logic                  wrap_pulse,
  output logic [WRAP_W-1:0]     wrap_count,
  output logic                  overrun
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [WIDTH-1:0] cand_p2;
  logic [CNT_W-1:0] stab_cnt;
  logic [WIDTH-1:0] cur;
  logic             cur_valid;
  logic             accept;
  logic             xfer;

  assign accept = (s2_p1 == cand_p2) && (stab_cnt == STAB_MAX) &&
                  ((cand_p2 != cur) || !cur_valid);
  assign xfer   = out_bus.out_valid && out_bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0             <= '0;
      s2_p1             <= '0;
      cand_p2           <= '0;
      stab_cnt          <= '0;
      cur               <= '0;
      cur_valid         <= 1'b0;
      out_bus.out_data  <= '0;
      out_bus.out_valid <= 1'b0;
      match_pulse       <= 1'b0;
      wrap_pulse        <= 1'b0;
      wrap_count        <= '0;
      overrun           <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer for the asynchronous counter bus
      s1_p0 <= q_in;
      s2_p1 <= s1_p0;

      // p2: candidate must stay unchanged for STABLE_CYCLES edges before acceptance
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      if (s2_p1 != cand_p2) begin
        cand_p2  <= s2_p1;
        stab_cnt <= '0;
      end else if (accept) begin
        cur       <= cand_p2;
        cur_valid <= 1'b1;
        // Events fire even when the buffer has to drop the value.
        if (cur_valid && (cand_p2 < cur)) begin
          wrap_pulse <= 1'b1;
          wrap_count <= sat_inc(wrap_count);
        end
        match_pulse <= cmp_en && (cand_p2 == cmp_value);
      end else if (stab_cnt < STAB_MAX) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      // p3: single-entry output buffer
      if (accept) begin
        if (!out_bus.out_valid || xfer) begin
          out_bus.out_data  <= cand_p2;
          out_bus.out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        out_bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Self-checking bench for ripple_count_sampler: directed scenarios plus a randomized
// run compared every cycle against a run-length based reference model.
module tb_ripple_count_sampler;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  q_in;
  logic          cmp_en;
  logic [W-1:0]  cmp_value;
  logic          match_pulse;
  logic          wrap_pulse;
  logic [WW-1:0] wrap_count;
  logic          overrun;

  ripple_count_sampler_if #(.WIDTH(W)) bus ();

  ripple_count_sampler #(.WIDTH(W), .STABLE_CYCLES(S), .WRAP_W(WW)) dut (
    .clk         (clk),
    .reset       (rst),
    .q_in        (q_in),
    .cmp_en      (cmp_en),
    .cmp_value   (cmp_value),
    .out_bus     (bus),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the synced stream is q_in delayed two edges; a value is accepted
  // once it has been seen on that stream for S+1 consecutive edges and differs from
  // the last accepted value.
  logic [W-1:0]  m_s1, m_s2, run_val, m_cur, m_data;
  int            run_len;
  logic          m_cur_valid, m_valid, m_match, m_wrap, m_ovr;
  logic [WW-1:0] m_wcount;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; run_val = '0; run_len = 1;
    m_cur = '0; m_cur_valid = 1'b0;
    m_data = '0; m_valid = 1'b0; m_match = 1'b0; m_wrap = 1'b0;
    m_wcount = '0; m_ovr = 1'b0;
  endtask

  task automatic step();
    logic [W-1:0] x;
    logic acc, xf;
    if (rst) begin
      model_reset();
    end else begin
      x = m_s2;
      m_s2 = m_s1;
      m_s1 = q_in;
      if (x == run_val) begin
        if (run_len < 100) run_len++;
      end else begin
        run_val = x;
        run_len = 1;
      end
      acc = (run_len >= S + 1) && (!m_cur_valid || run_val != m_cur);
      xf  = m_valid && bus.out_ready;
      m_match = 1'b0;
      m_wrap  = 1'b0;
      if (acc) begin
        if (m_cur_valid && run_val < m_cur) begin
          m_wrap = 1'b1;
          if (m_wcount != {WW{1'b1}}) m_wcount = m_wcount + 1'b1;
        end
        m_match = cmp_en && (run_val == cmp_value);
        if (!m_valid || xf) begin
          m_data  = run_val;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        m_cur = run_val;
        m_cur_valid = 1'b1;
      end else if (xf) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; q_in = '0; cmp_en = 1'b0; cmp_value = '0; bus.out_ready = 1'b0;
    step(); step();
    checks++;
    if ({bus.out_valid, bus.out_data, wrap_count, overrun, match_pulse, wrap_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h wc=%h ov=%b m=%b w=%b exp all zero",
               bus.out_valid, bus.out_data, wrap_count, overrun, match_pulse, wrap_pulse);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge1_valid got %b exp 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd0) begin
      errors++;
      $display("FAIL reset_edge2_accept got v=%b d=%h exp v=1 d=0", bus.out_valid, bus.out_data);
    end
    checks++;
    if (wrap_pulse !== 1'b0 || match_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_events got w=%b m=%b exp 0 0", wrap_pulse, match_pulse);
    end
  endtask

  task automatic test_latency();
    bus.out_ready = 1'b1;
    q_in = 4'd5;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early got v=%b d=%h exp v=0", bus.out_valid, bus.out_data);
        end
      end
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd5 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge5 got v=%b d=%h w=%b exp v=1 d=5 w=0",
               bus.out_valid, bus.out_data, wrap_pulse);
    end
  endtask

  task automatic test_glitch();
    int seen7, seen6;
    seen7 = 0; seen6 = 0;
    bus.out_ready = 1'b1;
    q_in = 4'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.out_valid && bus.out_data == 4'd7) seen7++;
    end
    q_in = 4'd6;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid && bus.out_data == 4'd7) seen7++;
      if (bus.out_valid && bus.out_data == 4'd6) seen6++;
    end
    checks++;
    if (seen7 != 0) begin
      errors++;
      $display("FAIL glitch_rejected got %0d cycles showing 7 exp 0", seen7);
    end
    checks++;
    if (seen6 == 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL glitch_delivery got seen6=%0d ov=%b exp seen6>0 ov=0", seen6, overrun);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] vals [3];
    int wraps, xfers;
    vals[0] = 4'd14; vals[1] = 4'd15; vals[2] = 4'd0;
    wraps = 0; xfers = 0;
    bus.out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      q_in = vals[v];
      for (int i = 0; i < 10; i++) begin
        if (bus.out_valid && bus.out_ready &&
            (bus.out_data == 4'd14 || bus.out_data == 4'd15 || bus.out_data == 4'd0)) xfers++;
        step();
        if (wrap_pulse) begin
          wraps++;
          checks++;
          if (bus.out_data !== 4'd0) begin
            errors++;
            $display("FAIL wrap_coincident got d=%h exp 0", bus.out_data);
          end
        end
      end
    end
    checks++;
    if (wraps != 1 || wrap_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_count got pulses=%0d wc=%0d exp 1 1", wraps, wrap_count);
    end
    checks++;
    if (xfers != 3) begin
      errors++;
      $display("FAIL wrap_transfers got %0d exp 3", xfers);
    end
  endtask

  task automatic test_match();
    int pulses;
    bus.out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      pulses = 0;
      cmp_en = (pass == 0);
      cmp_value = 4'd9;
      q_in = 4'd8;
      for (int i = 0; i < 10; i++) begin
        step();
        if (match_pulse) pulses++;
      end
      q_in = 4'd9;
      for (int i = 0; i < 10; i++) begin
        step();
        if (match_pulse) begin
          pulses++;
          checks++;
          if (bus.out_data !== 4'd9) begin
            errors++;
            $display("FAIL match_value got d=%h exp 9", bus.out_data);
          end
        end
      end
      checks++;
      if (pulses != ((pass == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL match_pulses_en%0d got %0d exp %0d", 1 - pass, pulses, (pass == 0) ? 1 : 0);
      end
    end
    cmp_en = 1'b0;
  endtask

  task automatic test_overrun();
    bus.out_ready = 1'b0;
    q_in = 4'd3;
    repeat (10) step();
    q_in = 4'd4;
    repeat (10) step();
    checks++;
    if (bus.out_data !== 4'd3 || bus.out_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold got d=%h v=%b ov=%b exp d=3 v=1 ov=1",
               bus.out_data, bus.out_valid, overrun);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_drain got v=%b exp 0", bus.out_valid);
    end
    checks++;
    if (wrap_count == 8'd0) begin
      errors++;
      $display("FAIL overrun_pre_reset_wraps got wc=%0d exp nonzero", wrap_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (overrun !== 1'b0 || wrap_count !== 8'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_reset got ov=%b wc=%0d v=%b exp 0 0 0", overrun, wrap_count, bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    int bad;
    bad = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 270; n++) begin
      for (int h = 0; h < 8; h++) begin
        q_in = (h < 4) ? 4'd1 : 4'd0;
        step();
        checks++;
        if ({bus.out_valid, bus.out_data, match_pulse, wrap_pulse, wrap_count, overrun} !==
            {m_valid, m_data, m_match, m_wrap, m_wcount, m_ovr}) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL saturate_cycle got %h exp %h",
                     {bus.out_valid, bus.out_data, match_pulse, wrap_pulse, wrap_count, overrun},
                     {m_valid, m_data, m_match, m_wrap, m_wcount, m_ovr});
        end
      end
    end
    checks++;
    if (wrap_count !== 8'hFF) begin
      errors++;
      $display("FAIL saturate_final got wc=%h exp ff", wrap_count);
    end
  endtask

  task automatic test_random();
    int hold, bad;
    bad = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 1500; ) begin
      q_in = W'($urandom_range(0, 15));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        cmp_en = $urandom_range(0, 1);
        cmp_value = W'($urandom_range(0, 15));
        rst = ($urandom_range(0, 199) == 0);
        step();
        c++;
        checks++;
        if ({bus.out_valid, bus.out_data, match_pulse, wrap_pulse, wrap_count, overrun} !==
            {m_valid, m_data, m_match, m_wrap, m_wcount, m_ovr}) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL random_cycle %0d got %h exp %h", c,
                     {bus.out_valid, bus.out_data, match_pulse, wrap_pulse, wrap_count, overrun},
                     {m_valid, m_data, m_match, m_wrap, m_wcount, m_ovr});
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; q_in = '0; cmp_en = 1'b0; cmp_value = '0; bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_wrap();
    test_match();
    test_overrun();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
